// File: rtl/pong_paddle_ctrl.sv
// Paddle controller for the VGA pong driver: synchronised buttons, move-rate tick,
// step acceleration and a paddle box clamped to a runtime play-field border.
module pong_paddle_ctrl #(
  parameter int COORD_W     = 10,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 64,
  parameter int X_OFFSET    = 16,
  parameter int INIT_Y      = 208,
  parameter int TICK_DIV    = 833334,
  parameter int BASE_STEP   = 2,
  parameter int MAX_STEP    = 8,
  parameter int ACCEL_TICKS = 6,
  parameter int ACCEL_EN    = 1
) (
  input  logic               CLK_100MHz,
  input  logic               Reset,
  input  logic               BtnUp,
  input  logic               BtnDown,
  input  logic               LR,
  input  logic [COORD_W-1:0] borderHmin,
  input  logic [COORD_W-1:0] borderHmax,
  input  logic [COORD_W-1:0] borderVmin,
  input  logic [COORD_W-1:0] borderVmax,
  output logic [COORD_W-1:0] Hmin,
  output logic [COORD_W-1:0] Hmax,
  output logic [COORD_W-1:0] Vmin,
  output logic [COORD_W-1:0] Vmax,
  output logic               moving,
  output logic               atTop,
  output logic               atBottom,
  output logic [1:0]         fsm_state
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ACC_W  = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
  localparam int EW     = COORD_W + 1;

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [ACC_W-1:0]   ACC_LAST  = ACC_W'(ACCEL_TICKS - 1);
  localparam logic [COORD_W-1:0] BASE_C    = COORD_W'(BASE_STEP);
  localparam logic [COORD_W-1:0] MAX_C     = COORD_W'(MAX_STEP);
  localparam logic [COORD_W-1:0] H_M1_C    = COORD_W'(PADDLE_H - 1);
  localparam logic [COORD_W-1:0] W_M1_C    = COORD_W'(PADDLE_W - 1);
  localparam logic [COORD_W-1:0] XOFF_C    = COORD_W'(X_OFFSET);
  localparam logic [COORD_W-1:0] INIT_VMIN = COORD_W'(INIT_Y);
  localparam logic [COORD_W-1:0] INIT_VMAX = COORD_W'(INIT_Y + PADDLE_H - 1);
  localparam logic [EW-1:0]      H_M1_E    = EW'(PADDLE_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  state_t state, state_nxt, last_move;

  logic               up_meta, up_sync, dn_meta, dn_sync;
  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic [COORD_W-1:0] step, step_use;
  logic [ACC_W-1:0]   acc_cnt;
  logic               dir_change;
  logic [EW-1:0]      vmin_e, vmax_e, bvmin_e, bvmax_e, step_e, cand;
  logic [COORD_W-1:0] low_c, v_next;

  // Two-flop synchronisers for the raw button levels.
  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      up_meta <= 1'b0;
      up_sync <= 1'b0;
      dn_meta <= 1'b0;
      dn_sync <= 1'b0;
    end else begin
      up_meta <= BtnUp;
      up_sync <= up_meta;
      dn_meta <= BtnDown;
      dn_sync <= dn_meta;
    end
  end

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // FSM: state register
  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state; both buttons together count as no input
  always_comb begin
    state_nxt = S_IDLE;
    if (up_sync && !dn_sync) begin
      state_nxt = S_UP;
    end else if (dn_sync && !up_sync) begin
      state_nxt = S_DOWN;
    end
  end

  // FSM: outputs
  always_comb begin
    moving = 1'b0;
    case (state)
      S_UP, S_DOWN: moving = 1'b1;
      default:      moving = 1'b0;
    endcase
  end

  assign fsm_state = state;

  // last_move remembers the state seen at the previous tick, so a reversal that
  // skipped IDLE still restarts the step on its first tick.
  assign dir_change = ((state == S_UP)   && (last_move == S_DOWN)) ||
                      ((state == S_DOWN) && (last_move == S_UP));
  assign step_use   = dir_change ? BASE_C : step;

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      step      <= BASE_C;
      acc_cnt   <= '0;
      last_move <= S_IDLE;
    end else if (tick) begin
      last_move <= state;
      if ((state == S_IDLE) || dir_change || (ACCEL_EN == 0)) begin
        step    <= BASE_C;
        acc_cnt <= '0;
      end else if (acc_cnt == ACC_LAST) begin
        acc_cnt <= '0;
        if (step < MAX_C) begin
          step <= step + 1'b1;
        end
      end else begin
        acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end

  assign low_c = borderVmax - H_M1_C;

  // Move candidate in one extra bit, then re-clamp into the (possibly shrunk) border.
  always_comb begin
    step_e  = {1'b0, step_use};
    vmin_e  = {1'b0, Vmin};
    vmax_e  = {1'b0, Vmax};
    bvmin_e = {1'b0, borderVmin};
    bvmax_e = {1'b0, borderVmax};
    cand    = vmin_e;
    case (state)
      S_UP:    cand = (vmin_e < bvmin_e + step_e) ? bvmin_e : vmin_e - step_e;
      S_DOWN:  cand = (vmax_e + step_e > bvmax_e) ? {1'b0, low_c} : vmin_e + step_e;
      default: cand = vmin_e;
    endcase
    v_next = cand[COORD_W-1:0];
    if (cand + H_M1_E > bvmax_e) begin
      v_next = low_c;
    end else if (cand < bvmin_e) begin
      v_next = borderVmin;
    end
  end

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      Vmin <= INIT_VMIN;
      Vmax <= INIT_VMAX;
    end else if (tick) begin
      Vmin <= v_next;
      Vmax <= v_next + H_M1_C;
    end
  end

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      Hmin <= '0;
      Hmax <= '0;
    end else if (LR) begin
      Hmax <= borderHmax - XOFF_C;
      Hmin <= borderHmax - XOFF_C - W_M1_C;
    end else begin
      Hmin <= borderHmin + XOFF_C;
      Hmax <= borderHmin + XOFF_C + W_M1_C;
    end
  end

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      atTop    <= 1'b0;
      atBottom <= 1'b0;
    end else begin
      atTop    <= (Vmin == borderVmin);
      atBottom <= (Vmax == borderVmax);
    end
  end

endmodule
